// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - decode/memory inputs and stall/flush/counter outputs of the hazard unit
interface hazard_unit_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       rs1;
   logic [4:0]       rs2;
   logic [4:0]       rs3;
   logic             dec_use1;
   logic             dec_use2;
   logic             dec_we;
   logic             redirect_M;
   logic             mem_req_M;
   logic             mem_ready;
   logic             stall_F;
   logic             stall_D;
   logic             stall_E;
   logic             stall_M;
   logic             stall_WB;
   logic             flush_F;
   logic             flush_D;
   logic             flush_E;
   logic             flush_M;
   logic             flush_WB;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output rs1, rs2, rs3, dec_use1, dec_use2, dec_we,
      output redirect_M, mem_req_M, mem_ready,
      input  stall_F, stall_D, stall_E, stall_M, stall_WB,
      input  flush_F, flush_D, flush_E, flush_M, flush_WB,
      input  mem_timeout, stall_cnt, flush_cnt
   );

   modport slave (
      input  rs1, rs2, rs3, dec_use1, dec_use2, dec_we,
      input  redirect_M, mem_req_M, mem_ready,
      output stall_F, stall_D, stall_E, stall_M, stall_WB,
      output flush_F, flush_D, flush_E, flush_M, flush_WB,
      output mem_timeout, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard unit: RAW scoreboard, redirect flush, memory-wait FSM with timeout
// Optional performance counters enabled by macro HAZARD_PERF_CNT_EN.
module hazard_unit #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input logic          clk,
   input logic          reset,
   hazard_unit_if.slave bus
);
   typedef enum logic [1:0] {BOOT, RUN, MEM_WAIT} state_t;

   localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

   state_t     state_q, state_d;
   logic [7:0] wait_q, wait_d;

   logic [4:0] e_rd, m_rd, wb_rd;
   logic       e_we, m_we, wb_we;

   logic s_f, s_d, s_e, s_m, s_wb;
   logic f_f, f_d, f_e, f_m, f_wb;
   logic tmo;

   logic mem_block;
   logic timeout_hit;
   logic raw1, raw2, raw;

   assign mem_block   = bus.mem_req_M && !bus.mem_ready;
   assign timeout_hit = (state_q == MEM_WAIT) && mem_block && (wait_q == TIMEOUT_VAL);

   // WB entries never hazard: the regfile writes on the falling edge, so decode reads the new value.
   assign raw1 = bus.dec_use1 && (bus.rs1 != 5'd0) &&
                 ((e_we && (e_rd == bus.rs1)) || (m_we && (m_rd == bus.rs1)));
   assign raw2 = bus.dec_use2 && (bus.rs2 != 5'd0) &&
                 ((e_we && (e_rd == bus.rs2)) || (m_we && (m_rd == bus.rs2)));
   assign raw  = raw1 || raw2;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= BOOT;
         wait_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      s_f = 1'b0; s_d = 1'b0; s_e = 1'b0; s_m = 1'b0; s_wb = 1'b0;
      f_f = 1'b0; f_d = 1'b0; f_e = 1'b0; f_m = 1'b0; f_wb = 1'b0;
      tmo = 1'b0;
      if (!reset) begin
         case (state_q)
            BOOT: begin
               s_f     = 1'b1;
               f_d     = 1'b1;
               f_e     = 1'b1;
               f_m     = 1'b1;
               f_wb    = 1'b1;
               state_d = RUN;
               wait_d  = 8'd0;
            end
            RUN, MEM_WAIT: begin
               if (mem_block && !timeout_hit) begin
                  // wait_q counts wait cycles already spent, including the RUN cycle that entered the wait
                  s_f     = 1'b1;
                  s_d     = 1'b1;
                  s_e     = 1'b1;
                  s_m     = 1'b1;
                  f_wb    = 1'b1;
                  state_d = MEM_WAIT;
                  wait_d  = 8'(wait_q + 8'd1);
               end else begin
                  state_d = RUN;
                  wait_d  = 8'd0;
                  tmo     = timeout_hit;
                  if (bus.redirect_M) begin
                     f_d = 1'b1;
                     f_e = 1'b1;
                     f_m = 1'b1;
                  end else if (raw) begin
                     s_f = 1'b1;
                     s_d = 1'b1;
                     f_e = 1'b1;
                  end
               end
            end
            default: begin
               state_d = BOOT;
               wait_d  = 8'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e_rd  <= 5'd0;
         e_we  <= 1'b0;
         m_rd  <= 5'd0;
         m_we  <= 1'b0;
         wb_rd <= 5'd0;
         wb_we <= 1'b0;
      end else begin
         if (!s_e) begin
            e_rd <= bus.rs3;
            e_we <= f_e ? 1'b0 : bus.dec_we;
         end
         if (!s_m) begin
            m_rd <= e_rd;
            m_we <= f_m ? 1'b0 : e_we;
         end
         if (!s_wb) begin
            wb_rd <= m_rd;
            wb_we <= f_wb ? 1'b0 : m_we;
         end
      end
   end

   // The WB entry is tracked to mirror the pipeline but feeds no hazard decision.
   logic wb_unused;
   assign wb_unused = ^{wb_rd, wb_we};

   assign bus.stall_F     = s_f;
   assign bus.stall_D     = s_d;
   assign bus.stall_E     = s_e;
   assign bus.stall_M     = s_m;
   assign bus.stall_WB    = s_wb;
   assign bus.flush_F     = f_f;
   assign bus.flush_D     = f_d;
   assign bus.flush_E     = f_e;
   assign bus.flush_M     = f_m;
   assign bus.flush_WB    = f_wb;
   assign bus.mem_timeout = tmo;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
   logic             redirect_flush;

   // Outside BOOT, flush_M can only come from a redirect.
   assign redirect_flush = (state_q != BOOT) && f_m;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (s_f && (state_q != BOOT))
            stall_cnt_q <= stall_cnt_q + 1'b1;
         if (redirect_flush)
            flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;
`else
   assign bus.stall_cnt = '0;
   assign bus.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - table-driven bench for hazard_unit with reset, boot, timeout and mid-wait reset sequences
module tb_hazard_unit;
   localparam int CNT_W = 32;

   // {stall F D E M WB, flush F D E M WB, mem_timeout}
   localparam logic [10:0] NONE = 11'b00000_00000_0;
   localparam logic [10:0] BOOT = 11'b10000_01111_0;
   localparam logic [10:0] RAW  = 11'b11000_00100_0;
   localparam logic [10:0] RED  = 11'b00000_01110_0;
   localparam logic [10:0] MEMW = 11'b11110_00001_0;
   localparam logic [10:0] TMO  = 11'b00000_00000_1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hazard_unit_if #(.CNT_W(CNT_W)) bus ();

   hazard_unit #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   wire [10:0] act = {bus.stall_F, bus.stall_D, bus.stall_E, bus.stall_M, bus.stall_WB,
                      bus.flush_F, bus.flush_D, bus.flush_E, bus.flush_M, bus.flush_WB,
                      bus.mem_timeout};

   typedef struct {
      logic [4:0]  rs1, rs2, rs3;
      logic        use1, use2, we, redir, req, rdy;
      logic [10:0] exp;
   } vec_t;

   vec_t tbl[28];
   int total = 0;
   int bad   = 0;

   function automatic vec_t mk(logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rs3,
                               logic use1, logic use2, logic we, logic redir,
                               logic req, logic rdy, logic [10:0] exp);
      vec_t v;
      v.rs1 = rs1; v.rs2 = rs2; v.rs3 = rs3;
      v.use1 = use1; v.use2 = use2; v.we = we;
      v.redir = redir; v.req = req; v.rdy = rdy; v.exp = exp;
      return v;
   endfunction

   task automatic drive(vec_t v);
      bus.rs1 = v.rs1; bus.rs2 = v.rs2; bus.rs3 = v.rs3;
      bus.dec_use1 = v.use1; bus.dec_use2 = v.use2; bus.dec_we = v.we;
      bus.redirect_M = v.redir; bus.mem_req_M = v.req; bus.mem_ready = v.rdy;
   endtask

   task automatic check(string name, logic [10:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   task automatic check_cnt(string name, logic [CNT_W-1:0] got, logic [CNT_W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, got, exp);
      end
   endtask

   task automatic step(vec_t v, string name);
      @(negedge clk);
      drive(v);
      #1 check(name, v.exp);
   endtask

   initial begin
      //            rs1 rs2 rs3 u1 u2 we rd rq rdy exp
      tbl[0]  = mk(0, 0, 5, 0, 0, 1, 0, 0, 0, NONE);
      tbl[1]  = mk(5, 0, 7, 1, 0, 1, 0, 0, 0, RAW);   // rd 5 in E
      tbl[2]  = mk(5, 0, 7, 1, 0, 1, 0, 0, 0, RAW);   // rd 5 in M
      tbl[3]  = mk(5, 0, 7, 1, 0, 1, 0, 0, 0, NONE);  // rd 5 in WB: free
      tbl[4]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, NONE);
      tbl[5]  = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, NONE);  // x0 in E with we=1
      tbl[6]  = mk(0, 9, 9, 0, 1, 1, 0, 0, 0, NONE);
      tbl[7]  = mk(9, 3, 0, 0, 1, 0, 0, 0, 0, NONE);  // rs1 matches but unused
      tbl[8]  = mk(0, 9, 0, 0, 1, 0, 0, 0, 0, RAW);   // rs2 vs M
      tbl[9]  = mk(0, 9, 0, 0, 1, 0, 0, 0, 0, NONE);
      tbl[10] = mk(0, 0, 4, 0, 0, 1, 0, 0, 0, NONE);
      tbl[11] = mk(4, 0, 0, 1, 0, 0, 1, 0, 0, RED);   // redirect beats RAW
      tbl[12] = mk(4, 0, 0, 1, 0, 0, 0, 0, 0, NONE);  // E/M were flushed
      tbl[13] = mk(0, 0, 6, 0, 0, 1, 0, 0, 0, NONE);
      tbl[14] = mk(6, 0, 0, 1, 0, 0, 1, 1, 0, MEMW);  // wait beats redirect+RAW
      tbl[15] = mk(6, 0, 0, 1, 0, 0, 1, 1, 0, MEMW);
      tbl[16] = mk(6, 0, 0, 1, 0, 0, 1, 1, 0, MEMW);
      tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, NONE);  // ready: clean cycle
      tbl[18] = mk(6, 0, 0, 1, 0, 0, 0, 0, 0, RAW);   // held E entry moved to M
      tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);
      tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MEMW);
      tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MEMW);
      tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MEMW);
      tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MEMW);
      tbl[24] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, TMO);   // 5th wait cycle
      tbl[25] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MEMW);
      tbl[26] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, NONE);
      tbl[27] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);

      // reset with noisy inputs: everything must stay low
      reset = 1'b1;
      drive(mk(3, 3, 3, 1, 1, 1, 1, 1, 0, NONE));
      @(negedge clk); #1 check("reset_a", NONE);
      @(negedge clk); #1 check("reset_b", NONE);
      check_cnt("reset_stall_cnt", bus.stall_cnt, '0);
      check_cnt("reset_flush_cnt", bus.flush_cnt, '0);

      @(negedge clk);
      reset = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
      #1 check("boot", BOOT);

      for (int i = 0; i < 28; i++)
         step(tbl[i], $sformatf("vec%0d", i));

      @(negedge clk);
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
      #1;
`ifdef HAZARD_PERF_CNT_EN
      check_cnt("stall_cnt", bus.stall_cnt, 32'd12);
      check_cnt("flush_cnt", bus.flush_cnt, 32'd1);
`else
      check_cnt("stall_cnt", bus.stall_cnt, '0);
      check_cnt("flush_cnt", bus.flush_cnt, '0);
`endif

      // reset in the middle of a memory wait
      step(mk(0, 0, 8, 0, 0, 1, 0, 0, 0, NONE), "mw_load");
      step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MEMW), "mw_wait1");
      step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MEMW), "mw_wait2");
      @(negedge clk);
      reset = 1'b1;
      #1 check("mw_reset", NONE);
      @(negedge clk);
      reset = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
      #1 check("mw_boot", BOOT);
      step(mk(8, 0, 0, 1, 0, 0, 0, 0, 0, NONE), "mw_sb_cleared");
      check_cnt("mw_stall_cnt", bus.stall_cnt, '0);
      step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MEMW), "mw_rewait");
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE), "mw_idle");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum number of MEM_WAIT cycles before a forced release.
REQ-002 Parameter CNT_W, default 32: width of the performance counters.
REQ-003 One clock, clk; reset is synchronous and active-high, named reset.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 rs1, rs2, rs3  in  5 each  decode-stage source and destination register indices.
REQ-007 dec_use1, dec_use2, dec_we  in  1 each  decode instruction reads rs1, reads rs2, writes rs3.
REQ-008 redirect_M  in  1  M-stage jump or taken branch; pc_SEL[0] is selecting pc_jump this cycle.
REQ-009 mem_req_M, mem_ready  in  1 each  M-stage load/store request, and data memory completion.
REQ-010 stall_F, stall_D, stall_E, stall_M, stall_WB  out  1 each  combinational stage holds.
REQ-011 flush_F, flush_D, flush_E, flush_M, flush_WB  out  1 each  combinational stage squashes.
REQ-012 mem_timeout  out  1  one-cycle pulse on forced MEM_WAIT release.
REQ-013 stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Function
REQ-014 The block SHALL keep a scoreboard (rd, we) for each of E, M and WB.
- The scoreboard advances only when the receiving stage is not stalled.
- A flushed stage loads we=0.
- E loads {rs3, dec_we}.
REQ-015 A RAW hazard SHALL be asserted when either condition holds, with index 0 never hazarding:
- (dec_use1 and rs1 != 0) and rs1 matches rd of a valid E or M entry;
- (dec_use2 and rs2 != 0) and rs2 matches rd of a valid E or M entry.
- A WB match is not a hazard, because the regfile writes on the falling edge.
REQ-016 On a RAW hazard: stall_F=1, stall_D=1, flush_E=1; all other outputs 0.
REQ-017 On redirect_M=1: flush_D=1, flush_E=1, flush_M=1; all other outputs 0.
- This overrides any RAW hazard in the same cycle.
REQ-018 The FSM SHALL have three states: BOOT, RUN, MEM_WAIT.
REQ-019 BOOT is entered on reset and lasts exactly one cycle, then goes to RUN.
- In BOOT: stall_F=1, flush_D=1, flush_E=1, flush_M=1, flush_WB=1.
REQ-020 RUN -> MEM_WAIT when mem_req_M=1 and mem_ready=0.
- The MEM_WAIT stall applies combinationally in that same cycle.
REQ-021 While mem_req_M=1, mem_ready=0 (RUN or MEM_WAIT):
- stall_F=1, stall_D=1, stall_E=1, stall_M=1, flush_WB=1.
- This has the highest priority: a redirect or RAW hazard in the same cycle is held, not acted on.
REQ-022 MEM_WAIT -> RUN in the cycle mem_ready=1; no stall that cycle.
REQ-023 An 8-bit wait counter SHALL count MEM_WAIT cycles.
- When it reaches MEM_TIMEOUT: pulse mem_timeout, release the stalls for one cycle, return to RUN and clear the counter.
REQ-024 The counter SHALL clear on every RUN entry.
REQ-025 Priority order: BOOT > MEM_WAIT > redirect > RAW > none.
REQ-026 With no condition active, all stall and flush outputs SHALL be 0.

Reset
REQ-027 During reset, all stall and flush outputs SHALL be 0, and mem_timeout=0.
REQ-028 Reset clears the scoreboard (all we=0), the wait counter and both performance counters, and sets the FSM to BOOT.
REQ-029 Reset asserted mid-MEM_WAIT SHALL abandon the wait; BOOT follows reset release.

Configuration
REQ-030 Macro HAZARD_PERF_CNT_EN.
- Defined: stall_cnt increments on each cycle with stall_F=1 outside BOOT.
- Defined: flush_cnt increments on each cycle with redirect-caused flushes.
- Both counters wrap at 2^CNT_W.
- Not defined: both ports are tied to 0 and no counter flops exist.

Verification
REQ-031 RAW hazard: E holds rd=5, we=1; decode rs1=5, dec_use1=1 -> stall_F=1, stall_D=1, flush_E=1 for one cycle; released the next cycle when rd=5 is in M? No: still stalled while rd=5 is in M; released when it reaches WB (2 cycles total).
REQ-032 x0 rule: rd=0 in E with we=1; rs1=0, dec_use1=1 -> no stall.
REQ-033 Redirect beats RAW: redirect_M=1 together with a RAW hazard -> flush_D, flush_E, flush_M = 1, stall_F=0.
- With the macro defined: flush_cnt increments by 1.
REQ-034 Memory wait: mem_req_M=1, mem_ready=0 for 3 cycles, then 1 -> 3 cycles of stall F/D/E/M plus flush_WB; 4th cycle clean; FSM returns to RUN.
REQ-035 Timeout: mem_ready held 0 with MEM_TIMEOUT=4 -> mem_timeout pulses in the 5th wait cycle; stalls drop that cycle.
REQ-036 Boot: reset released -> exactly one cycle with stall_F=1 and flush_D through flush_WB = 1, then all outputs 0.
